// File: rtl/readout_scheduler.sv
// readout_scheduler
//   Queues completed spectrogram banks, reads them back in order from the
//   single-port sample RAM and streams one sample per valid/ready handshake.
//   The memory-controller write path always owns the RAM when wr_en is high.
//
// Ports
//   clk, reset_n             : clock, asynchronous active-low reset
//   wr_en, wr_addr           : write request/address from the memory controller
//   bank0_full, bank1_full   : 1-cycle pulses, bank holds DEPTH samples
//   memorization_completed   : 1-cycle pulse, last-written bank is partial
//   idx_final                : last valid index of the partial bank
//   ram_addr, ram_we         : RAM address (write/read mux) and write enable
//   ram_rdata                : RAM read data, valid one cycle after address
//   out_data/valid/last/ready: streaming output handshake
//   pending                  : per-bank queued-for-readout flags
//   frame_drop               : 1-cycle pulse when a request is lost to overrun
//   busy                     : scheduler is not idle
module readout_scheduler #(
    parameter int unsigned DEPTH = 200,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [8:0]    wr_addr,
    input  logic          bank0_full,
    input  logic          bank1_full,
    input  logic          memorization_completed,
    input  logic [7:0]    idx_final,
    output logic [8:0]    ram_addr,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic [1:0]    pending,
    output logic          frame_drop,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_OUT
    } state_t;

    localparam logic [7:0] LP_FULL_M1 = 8'(DEPTH - 1);

    state_t        r_state;
    logic          r_rd_bank;
    logic [7:0]    r_rd_idx;
    logic [1:0]    r_pending;
    logic [7:0]    r_len0_m1;
    logic [7:0]    r_len1_m1;
    logic          r_last_wr_bank;
    logic          r_last_served;
    logic [DW-1:0] r_out_data;
    logic          r_out_valid;
    logic          r_out_last;
    logic          r_frame_drop;
    logic          r_busy;

    logic [1:0]    w_full;
    logic [1:0]    w_mc_hit;
    logic [1:0]    w_req;
    logic [1:0]    w_reading;
    logic [1:0]    w_blocked;
    logic [1:0]    w_accept;
    logic          w_drop;
    logic          w_pick;
    logic [7:0]    w_cur_len_m1;
    logic          w_done;
    logic [1:0]    w_clear;

    assign w_full    = {bank1_full, bank0_full};
    assign w_mc_hit  = memorization_completed ? (r_last_wr_bank ? 2'b10 : 2'b01) : 2'b00;
    // A full pulse on the same bank swallows a coincident partial request.
    assign w_req     = w_full | (w_mc_hit & ~w_full);
    assign w_reading = (r_state != S_IDLE) ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;
    assign w_blocked = r_pending | w_reading;
    assign w_accept  = w_req & ~w_blocked;
    assign w_drop    = |(w_req & w_blocked);
    // Both pending: alternate away from the bank served last.
    assign w_pick    = (&r_pending) ? ~r_last_served : r_pending[1];
    assign w_cur_len_m1 = r_rd_bank ? r_len1_m1 : r_len0_m1;
    assign w_done    = (r_state == S_OUT) && out_ready && r_out_last;
    assign w_clear   = w_done ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

    assign ram_we     = wr_en;
    assign ram_addr   = wr_en ? wr_addr : {r_rd_bank, r_rd_idx};
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign pending    = r_pending;
    assign frame_drop = r_frame_drop;
    assign busy       = r_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_rd_bank      <= 1'b0;
            r_rd_idx       <= '0;
            r_pending      <= '0;
            r_len0_m1      <= '0;
            r_len1_m1      <= '0;
            r_last_wr_bank <= 1'b0;
            r_last_served  <= 1'b1;
            r_out_data     <= '0;
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_frame_drop   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_frame_drop <= w_drop;
            if (wr_en) begin
                r_last_wr_bank <= wr_addr[8];
            end
            // Accepted requests never target a bank being cleared (it is blocked).
            r_pending <= (r_pending & ~w_clear) | w_accept;
            if (w_accept[0]) begin
                r_len0_m1 <= w_full[0] ? LP_FULL_M1 : idx_final;
            end
            if (w_accept[1]) begin
                r_len1_m1 <= w_full[1] ? LP_FULL_M1 : idx_final;
            end

            case (r_state)
                S_IDLE: begin
                    r_rd_idx <= '0;
                    if (|r_pending) begin
                        r_rd_bank <= w_pick;
                        r_busy    <= 1'b1;
                        r_state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (!wr_en) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_out_data  <= ram_rdata;
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_rd_idx == w_cur_len_m1);
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_out_last) begin
                            r_last_served <= r_rd_bank;
                            r_busy        <= 1'b0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_rd_idx <= r_rd_idx + 8'd1;
                            r_state  <= S_ADDR;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/readout_scheduler.md
# readout_scheduler

Sequences readout of the two 200-entry spectrogram banks and shares the single-port sample RAM between the memorization write path and a downstream streaming consumer. It sits between the memory controller, which writes frames and flags full banks, and the serial output stage. The write path always has priority. The scheduler queues completed banks, reads them back in order, and emits one sample per handshake, with a last-beat marker and overrun reporting.

## Interface
- DEPTH, 200, entries per bank; full-bank read length
- DW, 8, sample width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request from the memory controller; has priority over readout
- wr_addr  in  9  write address; bit 8 is the bank, bits 7:0 the index
- bank0_full, bank1_full  in  1 each  1-cycle pulse: bank holds DEPTH samples
- memorization_completed  in  1  1-cycle pulse: signal ended, and the last-written bank is partial
- idx_final  in  8  last valid index of the partial bank
- ram_addr  out  9  RAM address (mux of write and read)
- ram_we  out  1  RAM write enable; equals wr_en
- ram_rdata  in  DW  RAM read data, valid 1 cycle after address
- out_data  out  DW  streamed sample
- out_valid  out  1  out_data valid
- out_last  out  1  final sample of the current bank; qualified by out_valid
- out_ready  in  1  downstream accepts the beat when out_valid & out_ready
- pending  out  2  per-bank "queued for readout" flags
- frame_drop  out  1  1-cycle pulse: request lost to overrun
- busy  out  1  high in any state other than IDLE

## Operation
- Write arbitration (combinational)
  - ram_we = wr_en.
  - ram_addr = wr_addr when wr_en = 1; otherwise {rd_bank, rd_idx}.
- last_wr_bank register: loads wr_addr[8] on every cycle with wr_en = 1.
- Queueing
  - bankN_full pulse: sets pending[N] and len[N] = DEPTH.
  - memorization_completed pulse: sets pending[last_wr_bank] and len = idx_final + 1.
  - memorization_completed in the same cycle as bankN_full, with N = last_wr_bank: the full pulse wins, len = DEPTH, and no drop is reported.
- Overrun
  - Condition: a request targets a bank whose pending bit is already set, or the bank currently being read.
  - The existing request and length are kept, the new one is ignored, and frame_drop pulses for 1 cycle.
- Service order
  - From IDLE, when exactly one pending bit is set, serve that bank.
  - When both are set, serve the bank not equal to last_served. last_served resets to 1, so bank 0 goes first after reset.
- FSM (2-bit state)
  - IDLE: rd_idx = 0. If any pending bit is set, select rd_bank and go to ADDR.
  - ADDR: if wr_en = 1, stay (stall). Else drive the read address and go to WAIT.
  - WAIT: register ram_rdata into out_data and go to OUT.
  - OUT: out_valid = 1; out_last = (rd_idx == len[rd_bank] − 1). On out_valid & out_ready:
    - Last beat: clear pending[rd_bank], set last_served = rd_bank, go to IDLE.
    - Otherwise: rd_idx + 1, go to ADDR.
- While in OUT, out_data, out_valid and out_last are held stable until the beat is accepted.
- rd_idx is 8 bits and never exceeds 199. len is stored 8-bit as len − 1.

## Timing
- Reset: state IDLE; rd_idx, rd_bank, pending, len, last_wr_bank, out_data = 0; last_served = 1; all outputs 0.
- reset_n asserted mid-stream: the stream aborts, and queued requests are discarded.
- Pending bits and len update on the clock edge after the pulse. The earliest ADDR is 2 cycles after a full pulse (pulse edge, then IDLE→ADDR).
- Read latency is ADDR → WAIT → OUT, so out_valid rises 2 cycles after an unstalled ADDR. Peak rate is 1 beat per 3 cycles with out_ready tied high.
- Each wr_en cycle seen in ADDR adds 1 cycle of stall; the read address is never driven while wr_en = 1.
- A new pending request arriving while busy is served after the current bank finishes. The scheduler returns to IDLE for 1 cycle between banks.

## Test plan
- Full bank: write 200 samples (value = index) to bank 0, pulse bank0_full, out_ready = 1 → 200 beats carrying 0..199, out_last only on beat 199, pending = 00 afterwards, 3-cycle beat spacing.
- Partial bank: 37 writes to bank 1 with idx_final = 36, pulse memorization_completed → 37 beats, out_last on the beat with data 36, pending[1] cleared.
- Write priority: during readout, assert wr_en for 4 cycles while in ADDR → ram_addr equals wr_addr for those cycles, readout stalls by 4 cycles, and no sample is skipped or duplicated.
- Backpressure and order: both banks pending, out_ready toggling 1/0 → bank 0 is fully streamed before bank 1, and out_data is stable while out_ready = 0.
- Overrun: pulse bank0_full twice while bank 0 is still pending → exactly 1 frame_drop pulse, and a single 200-beat stream.
- Reset mid-stream: drop reset_n after beat 50 → outputs go to 0 immediately, pending = 00, and the scheduler is idle after release.
